// File: rtl/seq_detect_multi.sv
// Multi-pattern byte-sequence detector for the UART receive path.
// Ports: clk, rst_n, op_data/op_flag byte stream, det_clr, seq_pattern/seq_led/seq_en
// pattern table, led_out, match_flag, match_id, timeout_flag.
module seq_detect_multi #(
  parameter int DATA_W = 8,
  parameter int SEQ_LEN = 4,
  parameter int NUM_SEQ = 2,
  parameter int LED_W = 4,
  parameter logic [LED_W-1:0] LED_RST = {LED_W{1'b1}},
  parameter int TIMEOUT_CYC = 0,
  parameter int ID_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_W-1:0]                 op_data,
  input  logic                              op_flag,
  input  logic                              det_clr,
  input  logic [NUM_SEQ*SEQ_LEN*DATA_W-1:0] seq_pattern,
  input  logic [NUM_SEQ*LED_W-1:0]          seq_led,
  input  logic [NUM_SEQ-1:0]                seq_en,
  output logic [LED_W-1:0]                  led_out,
  output logic                              match_flag,
  output logic [ID_W-1:0]                   match_id,
  output logic                              timeout_flag
);

  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam int IW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int PW = SEQ_LEN * DATA_W;
  localparam logic [CW-1:0] CNT_FULL = CW'(SEQ_LEN);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);

  // Element 0 is the oldest byte, so it lines up with pattern byte k=0.
  typedef logic [SEQ_LEN-1:0][DATA_W-1:0] win_t;

  win_t              win_q, win_d, win_nxt;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_nxt;
  logic [IW-1:0]     idle_q, idle_d, idle_inc;
  logic [LED_W-1:0]  led_q, led_d, win_led;
  logic              match_flag_q, match_flag_d;
  logic [ID_W-1:0]   match_id_q, match_id_d, win_id;
  logic              timeout_q, timeout_d;
  logic [NUM_SEQ-1:0] hit;
  logic              any_hit;

  always_comb begin
    win_nxt = win_q;
    for (int k = 0; k < SEQ_LEN - 1; k++) begin
      win_nxt[k] = win_q[k+1];
    end
    win_nxt[SEQ_LEN-1] = op_data;
    cnt_nxt = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SEQ; i++) begin
      hit[i] = seq_en[i] && (cnt_nxt == CNT_FULL)
               && (win_nxt == seq_pattern[i*PW +: PW]);
    end
  end

  // Scan downward so the lowest hitting index is the one that sticks.
  always_comb begin
    any_hit = |hit;
    win_id  = '0;
    win_led = '0;
    for (int i = NUM_SEQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_id  = ID_W'(i);
        win_led = seq_led[i*LED_W +: LED_W];
      end
    end
  end

  always_comb begin
    win_d        = win_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    idle_inc     = idle_q + 1'b1;
    led_d        = led_q;
    match_flag_d = 1'b0;
    match_id_d   = match_id_q;
    timeout_d    = 1'b0;
    if (det_clr) begin
      cnt_d  = '0;
      idle_d = '0;
    end else if (op_flag) begin
      win_d  = win_nxt;
      cnt_d  = cnt_nxt;
      idle_d = '0;
      if (any_hit) begin
        match_flag_d = 1'b1;
        match_id_d   = win_id;
        led_d        = win_led;
      end
    end else if ((TIMEOUT_CYC > 0) && (idle_q != IDLE_MAX)) begin
      idle_d = idle_inc;
      // Fires only on the step that reaches the limit; once saturated
      // the counter stays put until the next byte.
      if ((idle_inc == IDLE_MAX) && (cnt_q != '0)) begin
        cnt_d     = '0;
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      led_q        <= LED_RST;
      match_flag_q <= 1'b0;
      match_id_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      led_q        <= led_d;
      match_flag_q <= match_flag_d;
      match_id_q   <= match_id_d;
      timeout_q    <= timeout_d;
    end
  end

  assign led_out      = led_q;
  assign match_flag   = match_flag_q;
  assign match_id     = match_id_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_seq_detect_multi.sv
// Self-checking bench for seq_detect_multi (TIMEOUT_CYC=16).
// Table vectors, hand-written corner sequences and random traffic vs a queue model.
module tb_seq_detect_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  op_data = '0;
  logic        op_flag = 1'b0;
  logic        det_clr = 1'b0;
  logic [63:0] seq_pattern = 64'h88776655_DDCCBBAA;
  logic [7:0]  seq_led = 8'hF0;
  logic [1:0]  seq_en = 2'b11;
  logic [3:0]  led_out;
  logic        match_flag;
  logic [0:0]  match_id;
  logic        timeout_flag;

  seq_detect_multi #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_data(op_data), .op_flag(op_flag),
    .det_clr(det_clr), .seq_pattern(seq_pattern), .seq_led(seq_led),
    .seq_en(seq_en), .led_out(led_out), .match_flag(match_flag),
    .match_id(match_id), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: history is simply the queue of the last 4 bytes.
  logic [7:0] mq[$];
  int         m_idle;
  logic [3:0] m_led;
  logic       m_id;
  logic       m_mf;
  logic       m_tf;

  function automatic void model_step(input logic op, input logic [7:0] d,
                                     input logic clr);
    logic ok;
    m_mf = 1'b0;
    m_tf = 1'b0;
    if (clr) begin
      mq.delete();
      m_idle = 0;
    end else if (op) begin
      mq.push_back(d);
      if (mq.size() > 4) void'(mq.pop_front());
      m_idle = 0;
      if (mq.size() == 4) begin
        for (int i = 0; i < 2; i++) begin
          if (!m_mf && seq_en[i]) begin
            ok = 1'b1;
            for (int k = 0; k < 4; k++)
              if (mq[k] != seq_pattern[(i*4+k)*8 +: 8]) ok = 1'b0;
            if (ok) begin
              m_mf  = 1'b1;
              m_id  = 1'(i);
              m_led = seq_led[i*4 +: 4];
            end
          end
        end
      end
    end else if (m_idle < 16) begin
      m_idle++;
      if (m_idle == 16 && mq.size() != 0) begin
        mq.delete();
        m_tf = 1'b1;
      end
    end
  endfunction

  task automatic cyc(input logic op, input logic [7:0] d, input logic clr);
    op_flag = op;
    op_data = d;
    det_clr = clr;
    @(posedge clk);
    model_step(op, d, clr);
    #1;
    chk("model_match_flag", match_flag, m_mf);
    chk("model_match_id", match_id, m_id);
    chk("model_led_out", led_out, m_led);
    chk("model_timeout_flag", timeout_flag, m_tf);
  endtask

  task automatic byte_in(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic feed3();
    byte_in(8'hAA); byte_in(8'hBB); byte_in(8'hCC);
  endtask

  task automatic feed4();
    feed3(); byte_in(8'hDD);
  endtask

  task automatic do_reset();
    op_flag = 1'b0;
    det_clr = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    m_idle = 0;
    m_led = 4'hF;
    m_id = 1'b0;
    m_mf = 1'b0;
    m_tf = 1'b0;
    #2;
    chk("rst_led_out", led_out, 4'hF);
    chk("rst_match_flag", match_flag, 0);
    chk("rst_match_id", match_id, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
    #10;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       op;
    logic [7:0] d;
    logic       clr;
    logic       mf;
    logic       id;
    logic [3:0] led;
  } vec_t;

  vec_t       tbl[8];
  int         t;
  int         n;
  int         r;
  int         p;
  logic [5:0] m;
  logic [3:0] led0;
  logic [7:0] pool[8];

  initial begin
    tbl[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 4'hF};
    tbl[1] = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 4'hF};
    tbl[2] = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 4'hF};
    tbl[3] = '{1'b1, 8'hDD, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[5] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[6] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[7] = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b1, 4'hF};
    pool = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66, 8'h77, 8'h88};

    do_reset();
    idle(3);
    chk("idle_led_out", led_out, 4'hF);
    chk("idle_match_flag", match_flag, 0);

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].op, tbl[i].d, tbl[i].clr);
      chk("tbl_match_flag", match_flag, tbl[i].mf);
      chk("tbl_match_id", match_id, tbl[i].id);
      chk("tbl_led_out", led_out, tbl[i].led);
      idle(9);
      chk("tbl_pulse_gone", match_flag, 0);
    end

    clr();
    n = 0;
    byte_in(8'hAA); n += match_flag;
    feed4(); n += match_flag;
    chk("overlap_count", n, 1);
    chk("overlap_id", match_id, 0);

    seq_pattern[31:0] = 32'h11111111;
    clr();
    m = '0;
    repeat (6) begin
      byte_in(8'h11);
      m = {m[4:0], match_flag};
    end
    chk("periodic_mask", m, 6'b000111);
    seq_pattern[31:0] = 32'hDDCCBBAA;

    clr();
    feed3();
    led0 = led_out;
    t = 0;
    repeat (16) begin
      cyc(1'b0, 8'h00, 1'b0);
      t += timeout_flag;
    end
    byte_in(8'hDD);
    chk("timeout_pulses", t, 1);
    chk("timeout_no_match", match_flag, 0);
    chk("timeout_led_hold", led_out, led0);

    clr();
    feed3();
    t = 0;
    repeat (15) begin
      cyc(1'b0, 8'h00, 1'b0);
      t += timeout_flag;
    end
    byte_in(8'hDD);
    chk("gap15_pulses", t, 0);
    chk("gap15_match", match_flag, 1);

    seq_pattern[63:32] = 32'hDDCCBBAA;
    clr(); feed4();
    chk("prio_match", match_flag, 1);
    chk("prio_id", match_id, 0);
    seq_en = 2'b10;
    clr(); feed4();
    chk("en10_match", match_flag, 1);
    chk("en10_id", match_id, 1);
    chk("en10_led", led_out, 4'hF);
    seq_en = 2'b00;
    clr(); feed4();
    chk("en00_no_match", match_flag, 0);
    seq_en = 2'b11;
    seq_pattern[63:32] = 32'h88776655;

    clr(); feed4();
    feed3();
    do_reset();
    byte_in(8'hDD);
    chk("rstmid_no_match", match_flag, 0);
    chk("rstmid_led", led_out, 4'hF);

    feed4();
    chk("pre_clr_led", led_out, 4'h0);
    feed3();
    clr();
    byte_in(8'hDD);
    chk("clrmid_no_match", match_flag, 0);
    chk("clrmid_led", led_out, 4'h0);

    feed3();
    cyc(1'b1, 8'hDD, 1'b1);
    chk("clr_with_byte", match_flag, 0);
    byte_in(8'hDD);
    chk("clr_byte_dropped", match_flag, 0);

    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        seq_en = 2'($urandom);
      end else if (r < 5) begin
        seq_pattern[63:32] = ($urandom_range(0, 1) != 0) ?
                             32'hDDCCBBAA : 32'h88776655;
      end else if (r < 6) begin
        do_reset();
      end else if (r < 12) begin
        idle($urandom_range(12, 20));
      end else if (r < 40) begin
        p = $urandom_range(0, 1);
        for (int k = 0; k < 4; k++) begin
          byte_in(seq_pattern[(p*4+k)*8 +: 8]);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
      end else begin
        cyc($urandom_range(0, 2) != 0,
            ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                        : pool[$urandom_range(0, 7)],
            $urandom_range(0, 39) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
